rota_toplayici: RTL and testbench

- Upstream feeder for the 6-bit route validator (`rotadogrula`).
- Collects a route serially, one bit per valid strobe, MSB first, into a shift register and presents the 6-bit word on `rota`.
- Samples the validator's combinational `rota_dogru` verdict, pulses accept or reject, and counts consecutive failures.
- After too many consecutive failures, enters a timed lockout during which input is ignored.

---
 rtl/rota_toplayici.sv | 149 ++++++++++++++
 tb/tb_rota_toplayici.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rota_toplayici.sv
// Serial route collector feeding the rotadogrula validator, with reject counting and timed lockout.
// Optional idle-timeout discard of partial entries is enabled by defining ROTA_ZAMAN_ASIMI_EN.
module rota_toplayici #(
    parameter int ROTA_W      = 6,
    parameter int MAX_HATA    = 3,
    parameter int KILIT_SURE  = 16,
    parameter int ZAMAN_ASIMI = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_gecerli,
    input  logic              bit_deger,
    input  logic              rota_dogru,
    output logic [ROTA_W-1:0] rota,
    output logic              rota_hazir,
    output logic              kabul,
    output logic              red,
    output logic              kilit,
    output logic [3:0]        hata_sayisi
);

    localparam int CNT_W = (ROTA_W > 2) ? $clog2(ROTA_W) : 1;
    localparam int TMR_W = (KILIT_SURE > 1) ? $clog2(KILIT_SURE) : 1;

    typedef enum logic [1:0] {TOPLA, KONTROL, KILIT} state_t;

    state_t              state_q, state_d;
    logic [ROTA_W-1:0]   rota_q, rota_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [3:0]          hata_q, hata_d;
    logic                hazir_q, hazir_d;
    logic                kabul_q, kabul_d;
    logic                red_q, red_d;
    logic                kilit_q, kilit_d;

`ifdef ROTA_ZAMAN_ASIMI_EN
    localparam int IDLE_W = (ZAMAN_ASIMI > 2) ? $clog2(ZAMAN_ASIMI) : 1;
    logic [IDLE_W-1:0]   idle_q, idle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    localparam int unused_zaman_asimi = ZAMAN_ASIMI;
`endif

    always_comb begin
        state_d = state_q;
        rota_d  = rota_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        hata_d  = hata_q;
        hazir_d = 1'b0;
        kabul_d = 1'b0;
        red_d   = 1'b0;
        kilit_d = 1'b0;
`ifdef ROTA_ZAMAN_ASIMI_EN
        idle_d  = '0;
`endif
        case (state_q)
            TOPLA: begin
                if (bit_gecerli) begin
                    rota_d = {rota_q[ROTA_W-2:0], bit_deger};
                    if (cnt_q == CNT_W'(ROTA_W - 1)) begin
                        cnt_d   = '0;
                        state_d = KONTROL;
                        hazir_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef ROTA_ZAMAN_ASIMI_EN
                // A stalled partial entry is silently dropped; it is not a reject.
                else if (cnt_q != '0) begin
                    if (idle_q == IDLE_W'(ZAMAN_ASIMI - 1)) begin
                        cnt_d  = '0;
                        rota_d = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            KONTROL: begin
                state_d = TOPLA;
                if (rota_dogru) begin
                    kabul_d = 1'b1;
                    hata_d  = 4'd0;
                end else begin
                    red_d = 1'b1;
                    if ((5'(hata_q) + 5'd1) < 5'(MAX_HATA)) begin
                        hata_d = hata_q + 4'd1;
                    end else begin
                        hata_d  = 4'(MAX_HATA);
                        state_d = KILIT;
                        timer_d = TMR_W'(KILIT_SURE - 1);
                        kilit_d = 1'b1;
                    end
                end
            end
            KILIT: begin
                // Bits strobed while locked are discarded by simply not looking at them.
                if (timer_q == '0) begin
                    state_d = TOPLA;
                    hata_d  = 4'd0;
                    rota_d  = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                    kilit_d = 1'b1;
                end
            end
            default: state_d = TOPLA;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TOPLA;
            rota_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            hata_q  <= 4'd0;
            hazir_q <= 1'b0;
            kabul_q <= 1'b0;
            red_q   <= 1'b0;
            kilit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rota_q  <= rota_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            hata_q  <= hata_d;
            hazir_q <= hazir_d;
            kabul_q <= kabul_d;
            red_q   <= red_d;
            kilit_q <= kilit_d;
        end
    end

    assign rota        = rota_q;
    assign rota_hazir  = hazir_q;
    assign kabul       = kabul_q;
    assign red         = red_q;
    assign kilit       = kilit_q;
    assign hata_sayisi = hata_q;

endmodule

// File: tb/tb_rota_toplayici.sv
// Directed self-checking bench for rota_toplayici with a behavioural route validator.
// Timeout expectations follow whether ROTA_ZAMAN_ASIMI_EN is defined.
module tb_rota_toplayici;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_gecerli;
    logic       bit_deger;
    logic       rota_dogru;
    logic [5:0] rota;
    logic       rota_hazir;
    logic       kabul;
    logic       red;
    logic       kilit;
    logic [3:0] hata_sayisi;

    int errors = 0;
    int checks = 0;

    rota_toplayici dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bit_gecerli (bit_gecerli),
        .bit_deger   (bit_deger),
        .rota_dogru  (rota_dogru),
        .rota        (rota),
        .rota_hazir  (rota_hazir),
        .kabul       (kabul),
        .red         (red),
        .kilit       (kilit),
        .hata_sayisi (hata_sayisi)
    );

    always #5 clk = ~clk;

    // Stand-in validator: only these routes are legal.
    function automatic logic validate(input logic [5:0] r);
        return (r == 6'b111000) || (r == 6'b100110) ||
               (r == 6'b100101) || (r == 6'b100011);
    endfunction

    assign rota_dogru = validate(rota);

    // Drive inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic applyStimulus(input logic v, input logic d);
        bit_gecerli = v;
        bit_deger   = d;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] check %s did not hold", tag);
        end
    endtask

    task automatic sendRoute(input logic [5:0] r);
        for (int i = 5; i >= 0; i--) applyStimulus(1'b1, r[i]);
    endtask

    task automatic checkVerdict(input string tag, input logic expKabul, input logic expRed,
                                input logic [3:0] expHata, input logic expKilit,
                                input logic [5:0] expRota);
        checkOutput({tag, "_hazir"}, 16'(rota_hazir), 16'd1);
        checkOutput({tag, "_rota"}, 16'(rota), 16'(expRota));
        checkOutput({tag, "_nopulse"}, 16'({kabul, red}), 16'd0);
        applyStimulus(1'b0, 1'b0);
        checkOutput({tag, "_pulse"}, 16'({kabul, red, rota_hazir}), 16'({expKabul, expRed, 1'b0}));
        checkOutput({tag, "_hata"}, 16'(hata_sayisi), 16'(expHata));
        checkOutput({tag, "_kilit"}, 16'(kilit), 16'(expKilit));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] r2;
        logic [5:0] r6;
        logic [5:0] hazRota;
        logic       sawK;
        logic       sawR;
        int         gaps[6];
        int         cnt;

        rst_n       = 1'b0;
        bit_gecerli = 1'b0;
        bit_deger   = 1'b0;
        #12;
        checkOutput("reset", 16'({rota, rota_hazir, kabul, red, kilit, hata_sayisi}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] consecutive bits 111000");
        sendRoute(6'b111000);
        checkVerdict("t1", 1'b1, 1'b0, 4'd0, 1'b0, 6'b111000);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1_single", 16'({kabul, red, rota_hazir}), 16'd0);

        $display("[TB] gapped bits 100110");
        r2   = 6'b100110;
        gaps = '{0, 1, 2, 3, 1, 0};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, r2[5-i]);
            if (i < 5) for (int g = 0; g < gaps[i]; g++) applyStimulus(1'b0, 1'b0);
            if (i == 2) checkOutput("t2_partial", 16'(rota), 16'(6'b000100));
        end
        checkVerdict("t2", 1'b1, 1'b0, 4'd0, 1'b0, 6'b100110);

        $display("[TB] three rejects into lockout");
        sendRoute(6'b000000);
        checkVerdict("t3a", 1'b0, 1'b1, 4'd1, 1'b0, 6'b000000);
        sendRoute(6'b101010);
        checkVerdict("t3b", 1'b0, 1'b1, 4'd2, 1'b0, 6'b101010);
        sendRoute(6'b111111);
        checkVerdict("t3c", 1'b0, 1'b1, 4'd3, 1'b1, 6'b111111);
        cnt = 0;
        while (kilit === 1'b1 && cnt < 40) begin
            cnt++;
            applyStimulus(1'b1, 1'b1);
        end
        checkOutput("t3_kilit_len", 16'(cnt), 16'd16);
        checkOutput("t3_after", 16'({rota, hata_sayisi, kilit}), 16'd0);

        $display("[TB] reject count cleared by accept");
        sendRoute(6'b000000);
        checkVerdict("t4a", 1'b0, 1'b1, 4'd1, 1'b0, 6'b000000);
        sendRoute(6'b101010);
        checkVerdict("t4b", 1'b0, 1'b1, 4'd2, 1'b0, 6'b101010);
        sendRoute(6'b100101);
        checkVerdict("t4c", 1'b1, 1'b0, 4'd0, 1'b0, 6'b100101);
        sendRoute(6'b111111);
        checkVerdict("t4d", 1'b0, 1'b1, 4'd1, 1'b0, 6'b111111);

        $display("[TB] asynchronous reset mid-entry and mid-lockout");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        bit_gecerli = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_entry", 16'({rota, rota_hazir, kabul, red, kilit, hata_sayisi}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sendRoute(6'b000000);
        checkVerdict("t5a", 1'b0, 1'b1, 4'd1, 1'b0, 6'b000000);
        sendRoute(6'b101010);
        checkVerdict("t5b", 1'b0, 1'b1, 4'd2, 1'b0, 6'b101010);
        sendRoute(6'b111111);
        checkVerdict("t5c", 1'b0, 1'b1, 4'd3, 1'b1, 6'b111111);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("t5_locked", 16'(kilit), 16'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_lock", 16'({rota, rota_hazir, kabul, red, kilit, hata_sayisi}), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sendRoute(6'b100011);
        checkVerdict("t5d", 1'b1, 1'b0, 4'd0, 1'b0, 6'b100011);

        $display("[TB] stale partial entry followed by 111000");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0);
`ifdef ROTA_ZAMAN_ASIMI_EN
        checkOutput("t6_discard", 16'(rota), 16'(6'b000000));
`else
        checkOutput("t6_stale", 16'(rota), 16'(6'b001110));
`endif
        r6      = 6'b111000;
        sawK    = 1'b0;
        sawR    = 1'b0;
        hazRota = 6'b000000;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) applyStimulus(1'b1, r6[5-i]);
            else       applyStimulus(1'b0, 1'b0);
            if (kabul) sawK = 1'b1;
            if (red)   sawR = 1'b1;
            if (rota_hazir) hazRota = rota;
        end
`ifdef ROTA_ZAMAN_ASIMI_EN
        checkOutput("t6_rota", 16'(hazRota), 16'(6'b111000));
        checkOutput("t6_verdict", 16'({sawK, sawR}), 16'(2'b10));
        checkOutput("t6_hata", 16'(hata_sayisi), 16'd0);
`else
        checkOutput("t6_rota", 16'(hazRota), 16'(6'b101110));
        checkOutput("t6_verdict", 16'({sawK, sawR}), 16'(2'b01));
        checkOutput("t6_hata", 16'(hata_sayisi), 16'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
